lcd_bus_arbiter: RTL
====================

// Module: lcd_bus_arbiter
// PURPOSE
//  Owns the HD44780-style LCD bus (EN/RW/RS/data) and arbitrates it between two byte-write requesters.
//  Requester 0 is the CPU result printer; requester 1 is the status/clear path.
//  Runs the power-up init sequence after reset, then serialises granted writes.
//  Every write uses a fixed setup/enable/hold timing, with an extended hold for slow commands.
// PARAMETERS
//  POWERUP_CYC  1_000_000  idle cycles after reset before first init write (>=1)
//  SETUP_CYC    2          cycles RS/data stable with EN=0 before EN rises (>=1)
//  PULSE_CYC    50_000     cycles EN held high (>=1)
//  HOLD_CYC     50_000     cycles EN low after pulse, normal writes (>=1)
//  LONG_CYC     100_000    hold cycles replacing HOLD_CYC for slow commands (>=HOLD_CYC)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  req_valid    in   2  per-requester write request; bit i = requester i
//  req_rs       in   2  per-requester RS (0 = command, 1 = character)
//  req_data     in   16 per-requester byte; [7:0] = req 0, [15:8] = req 1
//  req_ready    out  2  one-hot grant; a write is accepted when valid[i] && ready[i]
//  EN           out  1  LCD enable strobe
//  RW           out  1  LCD read/write select; tied 0 (write only)
//  RS           out  1  LCD register select
//  data         out  8  LCD data bus
//  busy         out  1  high in any state other than IDLE
//  init_done    out  1  high once the init sequence has completed
// BEHAVIOUR
//  Reset: one clk edge with rst=1 gives EN=0, RW=0, RS=0, data=8'h00, init_done=0, busy=1.
//   Also: state=PWRUP, counter=0, init_idx=0, last_grant=1 (requester 0 wins the first tie).
//  States: PWRUP -> SETUP -> PULSE -> HOLD -> {SETUP (init remaining) | IDLE}; IDLE -> SETUP on accept.
//  PWRUP: count POWERUP_CYC cycles, then load init ROM entry 0 and go to SETUP.
//   Init ROM, all with RS=0: 8'h38 (2 lines), 8'h0E (cursor on), 8'h01 (clear), 8'h06 (entry mode).
//  SETUP: RS/data driven, EN=0, for SETUP_CYC cycles. PULSE: EN=1 for PULSE_CYC cycles.
//   HOLD: EN=0 for HOLD_CYC cycles, or LONG_CYC when RS=0 and data is 8'h01, 8'h02 or 8'h03.
//  End of HOLD during init: if init_idx<3, increment it and load the next entry (SETUP).
//   Otherwise set init_done=1 and go to IDLE.
//  End of HOLD after init: go to IDLE.
//  RS/data stay registered and constant from SETUP entry until the next load.
//   RS/data hold their last value in IDLE.
//  req_ready is combinational: non-zero only when state==IDLE && init_done.
//   Exactly one bit is set, chosen from the currently valid requesters.
//   If one requester is valid, it is granted.
//   If both are valid, grant the one != last_grant (round-robin).
//   If neither is valid, req_ready = 0.
//  Accept at edge E: latch req_rs[i]/req_data[i], set last_grant=i, enter SETUP.
//   RS/data are visible from E+1; EN rises at E+1+SETUP_CYC.
//  Total occupancy per write = SETUP_CYC+PULSE_CYC+HOLD_CYC (or LONG_CYC) cycles, then >=1 IDLE cycle.
//   Back-to-back accepts are one IDLE cycle apart at best.
//  Requests arriving while busy are not lost: ready stays low, and the requester must hold valid/rs/data.
//  Dropping valid before acceptance withdraws the request; no side effects.
//  rst mid-write: EN=0 on the next edge, the latched write is discarded, and init reruns from PWRUP.
//  Counter: 32-bit down-counter, loaded with (N-1) on state entry; the state advances when it reads 0.
//  busy = (state != IDLE).
// STRUCTURE
//  lcd_pkg: state encoding (PWRUP, IDLE, SETUP, PULSE, HOLD).
//   Also: LCD command constants (CMD_FUNCSET 8'h38, CMD_DISPON 8'h0E, CMD_CLEAR 8'h01,
//   CMD_HOME 8'h02, CMD_ENTRY 8'h06, CMD_LINE2 8'hC0), INIT_LEN=4.
//  Sub-module lcd_phase_timer: loadable 32-bit down-counter with load/value/zero flag.
//   Instanced once; the FSM loads it per phase.
//  Arbiter, init ROM and FSM stay in this module.
// TESTING  (bench params: POWERUP=5, SETUP=1, PULSE=3, HOLD=4, LONG=8)
//  Reset, no requests -> EN pulses exactly 4 times, with data 38,0E,01,06 and RS=0 each.
//   The 01 pulse is followed by 8 low cycles, not 4; then init_done=1, req_ready=00.
//  After init, valid=01, rs0=1, data0=8'h41 -> ready=01 for 1 cycle; RS=1, data=41.
//   EN high for exactly 3 cycles, starting 1 cycle after RS/data settle.
//  Both valid continuously (d0=41, d1=53) -> grants alternate 0,1,0,1.
//   The data bus shows 41,53,41,53 and each requester gets 2 of 4 writes.
//  Requester 1 raises valid during requester 0's PULSE -> req_ready stays 00 until IDLE.
//   Then ready=10 and 53 is written unchanged.
//  Command rs=0, data=02 -> HOLD lasts 8 cycles. Command rs=0, data=C0 -> HOLD lasts 4 cycles.
//  rst asserted during PULSE -> EN=0 the next cycle, init_done=0.
//   The full init sequence repeats and the interrupted byte is never re-sent.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus arbiter:
// FSM state encoding, LCD command bytes, init ROM and arbitration helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNCSET = 8'h38;
  localparam logic [7:0] CMD_DISPON  = 8'h0E;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_LINE2   = 8'hC0;

  localparam int unsigned INIT_LEN = 4;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] val;
    case (idx)
      2'd0:    val = CMD_FUNCSET;
      2'd1:    val = CMD_DISPON;
      2'd2:    val = CMD_CLEAR;
      2'd3:    val = CMD_ENTRY;
      default: val = CMD_FUNCSET;
    endcase
    return val;
  endfunction

  // Clear, home and the undocumented 0x03 alias need the long settle time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && ((d == CMD_CLEAR) || (d == CMD_HOME) || (d == 8'h03));
  endfunction

  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic last);
    logic [1:0] g;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshake and LCD pin bundle for the LCD bus arbiter.
interface lcd_bus_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        EN;
  logic        RW;
  logic        RS;
  logic [7:0]  data;
  logic        busy;
  logic        init_done;

  modport master (
    output req_valid, req_rs, req_data,
    input  req_ready, EN, RW, RS, data, busy, init_done
  );

  modport slave (
    input  req_valid, req_rs, req_data,
    output req_ready, EN, RW, RS, data, busy, init_done
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable 32-bit down-counter that times each LCD bus phase; it parks at zero
// and reports it through zero_o until the next load.
module lcd_phase_timer #(
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] value_i,
  output logic        zero_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 32'd0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Owns the LCD bus: runs the power-up init sequence, then serialises byte
// writes from two requesters with round-robin arbitration and fixed timing.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC = 1000000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 50000,
  parameter int unsigned HOLD_CYC    = 50000,
  parameter int unsigned LONG_CYC    = 100000
) (
  input  logic              clk,
  input  logic              rst,
  lcd_bus_arbiter_if.slave  bus
);

  localparam logic [31:0] PWRUP_LD  = 32'(POWERUP_CYC - 32'd1);
  localparam logic [31:0] SETUP_LD  = 32'(SETUP_CYC - 32'd1);
  localparam logic [31:0] PULSE_LD  = 32'(PULSE_CYC - 32'd1);
  localparam logic [31:0] HOLD_LD   = 32'(HOLD_CYC - 32'd1);
  localparam logic [31:0] LONG_LD   = 32'(LONG_CYC - 32'd1);
  localparam logic [1:0]  INIT_LAST = 2'(INIT_LEN - 1);

  lcd_state_e  state_q, state_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, en_d;
  logic        init_done_q, init_done_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        last_grant_q, last_grant_d;

  logic [1:0]  grant_s;
  logic        tmr_load_s;
  logic [31:0] tmr_val_s;
  logic        tmr_zero_s;

  lcd_phase_timer #(
    .RESET_VAL (PWRUP_LD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load_s),
    .value_i (tmr_val_s),
    .zero_o  (tmr_zero_s)
  );

  always_comb begin
    grant_s = 2'b00;
    if ((state_q == ST_IDLE) && init_done_q) begin
      grant_s = rr_grant(bus.req_valid, last_grant_q);
    end else begin
      grant_s = 2'b00;
    end
  end

  // Each state lasts exactly (its timer load + 1) cycles; transitions reload the timer.
  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    data_d       = data_q;
    en_d         = 1'b0;
    init_done_d  = init_done_q;
    init_idx_d   = init_idx_q;
    last_grant_d = last_grant_q;
    tmr_load_s   = 1'b0;
    tmr_val_s    = 32'd0;
    case (state_q)
      ST_PWRUP: begin
        if (tmr_zero_s) begin
          rs_d       = 1'b0;
          data_d     = init_rom(2'd0);
          init_idx_d = 2'd0;
          state_d    = ST_SETUP;
          tmr_load_s = 1'b1;
          tmr_val_s  = SETUP_LD;
        end else begin
          state_d = ST_PWRUP;
        end
      end
      ST_IDLE: begin
        if (grant_s[0]) begin
          rs_d         = bus.req_rs[0];
          data_d       = bus.req_data[7:0];
          last_grant_d = 1'b0;
          state_d      = ST_SETUP;
          tmr_load_s   = 1'b1;
          tmr_val_s    = SETUP_LD;
        end else if (grant_s[1]) begin
          rs_d         = bus.req_rs[1];
          data_d       = bus.req_data[15:8];
          last_grant_d = 1'b1;
          state_d      = ST_SETUP;
          tmr_load_s   = 1'b1;
          tmr_val_s    = SETUP_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tmr_zero_s) begin
          state_d    = ST_PULSE;
          tmr_load_s = 1'b1;
          tmr_val_s  = PULSE_LD;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (tmr_zero_s) begin
          state_d    = ST_HOLD;
          tmr_load_s = 1'b1;
          tmr_val_s  = is_slow_cmd(rs_q, data_q) ? LONG_LD : HOLD_LD;
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_HOLD: begin
        if (!tmr_zero_s) begin
          state_d = ST_HOLD;
        end else if (init_done_q) begin
          state_d = ST_IDLE;
        end else if (init_idx_q != INIT_LAST) begin
          init_idx_d = init_idx_q + 2'd1;
          rs_d       = 1'b0;
          data_d     = init_rom(init_idx_q + 2'd1);
          state_d    = ST_SETUP;
          tmr_load_s = 1'b1;
          tmr_val_s  = SETUP_LD;
        end else begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_PWRUP;
        init_done_d = 1'b0;
        tmr_load_s  = 1'b1;
        tmr_val_s   = PWRUP_LD;
      end
    endcase
    en_d = (state_d == ST_PULSE);
  end

  // Registered state and LCD pins; reset abandons any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_PWRUP;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      en_q         <= 1'b0;
      init_done_q  <= 1'b0;
      init_idx_q   <= 2'd0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      en_q         <= en_d;
      init_done_q  <= init_done_d;
      init_idx_q   <= init_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.EN        = en_q;
  assign bus.RW        = 1'b0;
  assign bus.RS        = rs_q;
  assign bus.data      = data_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.init_done = init_done_q;

endmodule
